// File: rtl/key_encoder.sv
// ============================================================================
// key_encoder : four-key synchroniser, debouncer and priority encoder.
// Optional auto-repeat of press_stb when built with KEY_REPEAT_EN.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module key_encoder #(
  parameter int DB_MAX  = 16,
  parameter int DB_W    = 5,
  parameter int REP_DLY = 500,
  parameter int REP_PER = 100,
  parameter int REP_W   = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key0,
  input  logic key1,
  input  logic key2,
  input  logic key3,
  output logic out0,
  output logic out1,
  output logic valid,
  output logic press_stb,
  output logic multi
);

  if (DB_MAX < 1 || DB_MAX >= (1 << DB_W) ||
      REP_DLY < 1 || REP_PER < 1 ||
      REP_DLY >= (1 << REP_W) || REP_PER >= (1 << REP_W)) begin : g_param_check
    $error("key_encoder: counter widths cannot hold DB_MAX/REP_DLY/REP_PER");
  end

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      db_q;
  logic [DB_W-1:0] cnt_q [4];

  logic [1:0]      code_q, code_d;
  logic            valid_q, multi_q, stb_q, stb_d;
  logic [1:0]      enc_code;
  logic            enc_valid, enc_multi, stb_new, rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
    end else begin
      sync1_q <= {key3, key2, key1, key0};
      sync2_q <= sync1_q;
    end
  end

  // A key's debounced level flips only after DB_MAX consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= 4'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_W'(DB_MAX - 1)) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    enc_code = 2'd0;
    if (db_q[3])      enc_code = 2'd3;
    else if (db_q[2]) enc_code = 2'd2;
    else if (db_q[1]) enc_code = 2'd1;
    enc_valid = |db_q;
    enc_multi = ($countones(db_q) >= 2);
    stb_new   = enc_valid && (!valid_q || (enc_code != code_q));
    code_d    = enc_valid ? enc_code : code_q;
  end

`ifdef KEY_REPEAT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // The FSM follows the valid/code being loaded into the output registers this edge.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    if (!enc_valid) begin
      state_d   = S_IDLE;
      rep_cnt_d = '0;
    end else if (stb_new) begin
      state_d   = S_DELAY;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: rep_cnt_d = '0;
        S_DELAY: begin
          if (rep_cnt_q == REP_W'(REP_DLY - 1)) begin
            state_d   = S_REPEAT;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        S_REPEAT: begin
          if (rep_cnt_q == REP_W'(REP_PER - 1)) rep_cnt_d = '0;
          else                                  rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
        default: begin
          state_d   = S_IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    rep_fire = 1'b0;
    if (enc_valid && !stb_new) begin
      if (state_q == S_DELAY  && rep_cnt_q == REP_W'(REP_DLY - 1)) rep_fire = 1'b1;
      if (state_q == S_REPEAT && rep_cnt_q == REP_W'(REP_PER - 1)) rep_fire = 1'b1;
    end
  end
`else
  always_comb rep_fire = 1'b0;
`endif

  assign stb_d = stb_new | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 2'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= enc_valid;
      multi_q <= enc_multi;
      stb_q   <= stb_d;
    end
  end

  assign out0      = code_q[0];
  assign out1      = code_q[1];
  assign valid     = valid_q;
  assign multi     = multi_q;
  assign press_stb = stb_q;

endmodule

`default_nettype wire

// File: tb/tb_key_encoder.sv
// ============================================================================
// tb_key_encoder : self-checking bench for key_encoder (DB_MAX=4, REP 8/4).
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_key_encoder;

  localparam int DB_MAX  = 4;
  localparam int REP_DLY = 8;
  localparam int REP_PER = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key0 = 1'b0, key1 = 1'b0, key2 = 1'b0, key3 = 1'b0;
  logic out0, out1, valid, press_stb, multi;

  key_encoder #(
    .DB_MAX(DB_MAX), .DB_W(5), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .REP_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .out0(out0), .out1(out1), .valid(valid), .press_stb(press_stb), .multi(multi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: history of sampled raw keys; debounced level flips when the
  // last DB_MAX synchronised samples all disagree with it.
  logic [3:0] hist[$];
  logic [3:0] m_db;
  logic [1:0] m_code;
  logic       m_valid, m_multi, m_stb;
`ifdef KEY_REPEAT_EN
  int         age;
  bit         active;
`endif

  task automatic model_reset();
    m_db = 4'd0; m_code = 2'd0; m_valid = 1'b0; m_multi = 1'b0; m_stb = 1'b0;
    hist = {4'd0, 4'd0};
`ifdef KEY_REPEAT_EN
    age = 0; active = 1'b0;
`endif
  endtask

  task automatic model_step(input logic [3:0] k);
    logic       nv, nm, ns, rep, flip;
    logic [1:0] nc;
    logic [3:0] ndb;
    int         idx;
    nv = (m_db != 4'd0);
    nm = ($countones(m_db) >= 2);
    nc = 2'd0;
    for (int i = 0; i < 4; i++) if (m_db[i]) nc = 2'(i);
    ns  = nv && (!m_valid || nc != m_code);
    rep = 1'b0;
`ifdef KEY_REPEAT_EN
    if (ns) begin
      active = 1'b1; age = 0;
    end else if (nv && active) begin
      age++;
      if (age == REP_DLY || (age > REP_DLY && (age - REP_DLY) % REP_PER == 0)) rep = 1'b1;
    end else begin
      active = 1'b0;
    end
`endif
    if (nv) m_code = nc;
    m_valid = nv; m_multi = nm; m_stb = ns | rep;
    hist.push_back(k);
    ndb = m_db;
    for (int i = 0; i < 4; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DB_MAX; j++) begin
        idx = hist.size() - 3 - j;
        if (idx < 0) flip = 1'b0;
        else if (hist[idx][i] == m_db[i]) flip = 1'b0;
      end
      if (flip) ndb[i] = ~m_db[i];
    end
    m_db = ndb;
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  int         stb_tot = 0, stb_new = 0;
  logic       p_valid = 1'b0;
  logic [1:0] p_code = 2'd0;

  task automatic tick(input logic [3:0] k);
    logic [4:0] dv, mv;
    @(negedge clk);
    {key3, key2, key1, key0} = k;
    @(posedge clk);
    model_step(k);
    #1;
    dv = {out1, out0, valid, multi, press_stb};
    mv = {m_code, m_valid, m_multi, m_stb};
    chk("cycle", int'(dv), int'(mv));
    if (press_stb) begin
      stb_tot++;
      if (valid && (!p_valid || {out1, out0} != p_code)) stb_new++;
    end
    p_valid = valid;
    p_code  = {out1, out0};
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 chk("rst_async", int'({out1, out0, valid, multi, press_stb}), 0);
    #1 rst_n = 1'b1;
    model_reset();
    p_valid = 1'b0; p_code = 2'd0;
  endtask

  typedef struct {
    logic [3:0] keys;
    logic [1:0] code;
    logic       v;
    logic       m;
    int         nstb;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int first, s0, saw, saw_code, n;

    tbl[0]  = '{4'b0000, 2'd0, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'b0010, 2'd1, 1'b1, 1'b0, 1};
    tbl[2]  = '{4'b1010, 2'd3, 1'b1, 1'b1, 1};
    tbl[3]  = '{4'b0010, 2'd1, 1'b1, 1'b0, 1};
    tbl[4]  = '{4'b0000, 2'd1, 1'b0, 1'b0, 0};
    tbl[5]  = '{4'b1100, 2'd3, 1'b1, 1'b1, 1};
    tbl[6]  = '{4'b0100, 2'd2, 1'b1, 1'b0, 1};
    tbl[7]  = '{4'b0001, 2'd0, 1'b1, 1'b0, 1};
    tbl[8]  = '{4'b0011, 2'd1, 1'b1, 1'b1, 1};
    tbl[9]  = '{4'b0001, 2'd0, 1'b1, 1'b0, 1};
    tbl[10] = '{4'b0000, 2'd0, 1'b0, 1'b0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset", int'({out1, out0, valid, multi, press_stb}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // key1 held from a quiet start: first strobe exactly 2+DB_MAX+1 edges later
    first = -1; s0 = stb_tot;
    for (int i = 1; i <= 12; i++) begin
      tick(4'b0010);
      if (press_stb && first < 0) first = i;
    end
    chk("latency_stb_cycle", first, 7);
    chk("latency_stb_count", stb_tot - s0, 1);
    chk("latency_code", int'({out1, out0}), 1);
    repeat (12) tick(4'b0000);

    // glitches on key0: 3 cycles ignored, 4 cycles accepted
    s0 = stb_tot; saw = 0;
    repeat (3) tick(4'b0001);
    repeat (12) begin tick(4'b0000); if (valid) saw = 1; end
    chk("glitch3_stb", stb_tot - s0, 0);
    chk("glitch3_valid", saw, 0);
    s0 = stb_tot; saw = 0; saw_code = -1;
    for (int i = 0; i < 16; i++) begin
      tick(i < 4 ? 4'b0001 : 4'b0000);
      if (valid && saw == 0) begin saw = 1; saw_code = int'({out1, out0}); end
    end
    chk("glitch4_stb", stb_tot - s0, 1);
    chk("glitch4_valid", saw, 1);
    chk("glitch4_code", saw_code, 0);

    for (int v = 0; v < 11; v++) begin
      s0 = stb_new;
      repeat (12) tick(tbl[v].keys);
      chk($sformatf("tbl%0d_out", v), int'({out1, out0, valid, multi}),
          int'({tbl[v].code, tbl[v].v, tbl[v].m}));
      chk($sformatf("tbl%0d_stb", v), stb_new - s0, tbl[v].nstb);
    end

    // asynchronous reset with key2 held, then debounce restarts from scratch
    repeat (12) tick(4'b0100);
    chk("pre_reset_valid", int'(valid), 1);
    async_reset();
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(4'b0100);
      if (valid && first < 0) first = i;
    end
    chk("post_reset_valid_cycle", first, 7);
    repeat (12) tick(4'b0000);

    // key2 held 30 cycles past debounce
    s0 = stb_tot;
    repeat (37) tick(4'b0100);
`ifdef KEY_REPEAT_EN
    chk("hold_strobes", stb_tot - s0, 7);
`else
    chk("hold_strobes", stb_tot - s0, 1);
`endif
    n = 0;
    while (valid && n < 20) begin tick(4'b0000); n++; end
    chk("release_timeout", int'(valid), 0);
    s0 = stb_tot;
    repeat (10) tick(4'b0000);
    chk("release_strobes", stb_tot - s0, 0);

    // randomized key patterns against the reference model
    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] k;
      int hold;
      k    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 10);
      repeat (hold) tick(k);
      if (seg == 150) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
